// File: rtl/char_console.sv
// ----------------------------------------------------------------------------
// char_console
//   Terminal-style text writer that sits in front of the 80x50 character
//   display. It takes a byte stream of character codes with a 12-bit colour,
//   keeps a cursor, and writes VRAM words through the display's port A.
//   Line wrap, CR/LF/BS/form-feed and hardware scroll are supported. Scroll
//   copies VRAM through a read-then-write loop.
//
// Ports
//   CLK        system clock (same clock as VRAM port A)
//   RST        synchronous active-high reset
//   CH_VALID   character byte valid
//   CH_READY   console can accept a byte
//   CH_CODE    character / control code
//   CH_COLOR   {R,G,B}, 4 bits each, used for printable codes
//   WRADDR     VRAM write byte address {2'b00, index[11:0], 2'b00}
//   BYTEEN     byte enables, 4'b0111 while WREN is high, else 0
//   WREN       VRAM write strobe
//   WRDATA     {8'h00, 4'h0, color[11:0], 1'b0, code[6:0]}
//   RDADDR     VRAM read byte address, same format as WRADDR
//   RDEN       VRAM read strobe, never high together with WREN
//   RDDATA     VRAM read data, bits [23:0] used
//   CUR_COL    cursor column 0..COLS-1
//   CUR_ROW    cursor row 0..ROWS-1
//   BUSY       high in any state other than IDLE
//   DBG_STATE  current FSM state, for observation only
//
// Handshake: a byte moves on the rising CLK edge where CH_VALID and CH_READY
// are both high. CH_READY depends only on the FSM state (and on RST), never
// on CH_VALID. The producer holds CH_CODE and CH_COLOR stable while CH_VALID
// is high.
// ----------------------------------------------------------------------------
module char_console #(
    parameter int COLS   = 80,
    parameter int ROWS   = 50,
    parameter int RD_LAT = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CH_VALID,
    output logic        CH_READY,
    input  logic [7:0]  CH_CODE,
    input  logic [11:0] CH_COLOR,
    output logic [15:0] WRADDR,
    output logic [3:0]  BYTEEN,
    output logic        WREN,
    output logic [31:0] WRDATA,
    output logic [15:0] RDADDR,
    output logic        RDEN,
    input  logic [31:0] RDDATA,
    output logic [6:0]  CUR_COL,
    output logic [5:0]  CUR_ROW,
    output logic        BUSY,
    output logic [3:0]  DBG_STATE
);

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_PUT      = 4'd1;
    localparam logic [3:0] ST_NEWLINE  = 4'd2;
    localparam logic [3:0] ST_CLR      = 4'd3;
    localparam logic [3:0] ST_SCR_RD   = 4'd4;
    localparam logic [3:0] ST_SCR_WAIT = 4'd5;
    localparam logic [3:0] ST_SCR_WR   = 4'd6;
    localparam logic [3:0] ST_SCR_CLR  = 4'd7;

    localparam logic [11:0] COLS_W        = 12'(COLS);
    localparam logic [11:0] LAST_IDX      = 12'(COLS * ROWS - 1);
    localparam logic [11:0] SCR_LAST      = 12'((ROWS - 1) * COLS - 1);
    localparam logic [11:0] LAST_ROW_BASE = 12'((ROWS - 1) * COLS);
    localparam logic [6:0]  LAST_COL      = 7'(COLS - 1);
    localparam logic [5:0]  LAST_ROW      = 6'(ROWS - 1);
    localparam logic [3:0]  WAIT_LAST     = 4'(RD_LAT - 1);
    // Blank cell: space character, colour 0.
    localparam logic [23:0] BLANK         = 24'h000020;

    localparam logic [7:0] CODE_BS = 8'h08;
    localparam logic [7:0] CODE_LF = 8'h0A;
    localparam logic [7:0] CODE_FF = 8'h0C;
    localparam logic [7:0] CODE_CR = 8'h0D;

    logic [3:0]  state;
    logic [6:0]  col;
    logic [5:0]  row;
    // Word index being written: PUT target, clear index or scroll index.
    logic [11:0] cnt;
    logic [3:0]  wait_cnt;
    // Pending word in {4'h0, colour, bit7, code} layout (PUT data or
    // the word captured from RDDATA during scroll).
    logic [23:0] wr_data;
    logic [11:0] cur_idx;
    logic [11:0] row_w;
    logic        printable;
    logic        wr_active;
    logic        rd_active;
    logic [23:0] wr_word;
    logic [11:0] rd_idx;
    logic        rd_unused;

    // row*COLS + col as a constant shift-add over the set bits of COLS
    // (80 = 64 + 16), so no multiplier is built.
    assign row_w = {6'b000000, row};
    always_comb begin
        cur_idx = {5'b00000, col};
        for (int b = 0; b < 12; b++) begin
            if (COLS_W[b]) begin
                cur_idx = cur_idx + (row_w << b);
            end
        end
    end

    assign printable = (CH_CODE >= 8'h20) && (CH_CODE <= 8'h7E);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            col      <= '0;
            row      <= '0;
            cnt      <= '0;
            wait_cnt <= '0;
            wr_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (CH_VALID) begin
                        if (printable) begin
                            cnt     <= cur_idx;
                            wr_data <= {4'h0, CH_COLOR, 1'b0, CH_CODE[6:0]};
                            state   <= ST_PUT;
                        end else begin
                            case (CH_CODE)
                                CODE_CR: col <= '0;
                                CODE_BS: begin
                                    if (col != 7'd0) begin
                                        col <= col - 7'd1;
                                    end
                                end
                                // LF from IDLE resolves the row directly so
                                // a scroll starts on the next cycle.
                                CODE_LF: begin
                                    col <= '0;
                                    if (row == LAST_ROW) begin
                                        cnt   <= '0;
                                        state <= ST_SCR_RD;
                                    end else begin
                                        row <= row + 6'd1;
                                    end
                                end
                                CODE_FF: begin
                                    cnt   <= '0;
                                    state <= ST_CLR;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                ST_PUT: begin
                    if (col == LAST_COL) begin
                        col   <= '0;
                        state <= ST_NEWLINE;
                    end else begin
                        col   <= col + 7'd1;
                        state <= ST_IDLE;
                    end
                end
                ST_NEWLINE: begin
                    col <= '0;
                    if (row == LAST_ROW) begin
                        cnt   <= '0;
                        state <= ST_SCR_RD;
                    end else begin
                        row   <= row + 6'd1;
                        state <= ST_IDLE;
                    end
                end
                ST_CLR: begin
                    if (cnt == LAST_IDX) begin
                        cnt   <= '0;
                        col   <= '0;
                        row   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 12'd1;
                    end
                end
                ST_SCR_RD: begin
                    wait_cnt <= '0;
                    state    <= ST_SCR_WAIT;
                end
                ST_SCR_WAIT: begin
                    // RDDATA is valid in the RD_LAT-th cycle after RDEN.
                    if (wait_cnt == WAIT_LAST) begin
                        wr_data <= RDDATA[23:0];
                        state   <= ST_SCR_WR;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                ST_SCR_WR: begin
                    if (cnt == SCR_LAST) begin
                        cnt   <= LAST_ROW_BASE;
                        state <= ST_SCR_CLR;
                    end else begin
                        cnt   <= cnt + 12'd1;
                        state <= ST_SCR_RD;
                    end
                end
                ST_SCR_CLR: begin
                    if (cnt == LAST_IDX) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 12'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Strobes are decoded from the state, so at most one of them can be high
    // and both drop in the same cycle RST is raised.
    assign wr_active = ~RST && ((state == ST_PUT) || (state == ST_CLR) ||
                                (state == ST_SCR_WR) || (state == ST_SCR_CLR));
    assign rd_active = ~RST && (state == ST_SCR_RD);
    assign wr_word   = ((state == ST_PUT) || (state == ST_SCR_WR)) ? wr_data : BLANK;
    assign rd_idx    = cnt + COLS_W;

    assign WREN   = wr_active;
    assign BYTEEN = wr_active ? 4'b0111 : 4'b0000;
    assign WRADDR = wr_active ? {2'b00, cnt, 2'b00} : 16'h0000;
    assign WRDATA = wr_active ? {8'h00, wr_word[23:8], 1'b0, wr_word[6:0]} : 32'h0;
    assign RDEN   = rd_active;
    assign RDADDR = rd_active ? {2'b00, rd_idx, 2'b00} : 16'h0000;

    assign CH_READY  = ~RST && (state == ST_IDLE);
    assign BUSY      = (state != ST_IDLE);
    assign CUR_COL   = col;
    assign CUR_ROW   = row;
    assign DBG_STATE = state;

    // Bits that are deliberately dropped.
    assign rd_unused = ^{RDDATA[31:24], wr_data[7]};

endmodule

// File: tb/tb_char_console.sv
// ----------------------------------------------------------------------------
// tb_char_console
//   Directed bench for char_console: VRAM model with one cycle read latency,
//   write log compared against an expected queue, and a summary line.
// ----------------------------------------------------------------------------
module tb_char_console;

    logic        CLK;
    logic        RST;
    logic        CH_VALID;
    logic        CH_READY;
    logic [7:0]  CH_CODE;
    logic [11:0] CH_COLOR;
    logic [15:0] WRADDR;
    logic [3:0]  BYTEEN;
    logic        WREN;
    logic [31:0] WRDATA;
    logic [15:0] RDADDR;
    logic        RDEN;
    logic [31:0] RDDATA;
    logic [6:0]  CUR_COL;
    logic [5:0]  CUR_ROW;
    logic        BUSY;
    logic [3:0]  DBG_STATE;

    char_console dut (
        .CLK       (CLK),
        .RST       (RST),
        .CH_VALID  (CH_VALID),
        .CH_READY  (CH_READY),
        .CH_CODE   (CH_CODE),
        .CH_COLOR  (CH_COLOR),
        .WRADDR    (WRADDR),
        .BYTEEN    (BYTEEN),
        .WREN      (WREN),
        .WRDATA    (WRDATA),
        .RDADDR    (RDADDR),
        .RDEN      (RDEN),
        .RDDATA    (RDDATA),
        .CUR_COL   (CUR_COL),
        .CUR_ROW   (CUR_ROW),
        .BUSY      (BUSY),
        .DBG_STATE (DBG_STATE)
    );

    // ---------------- clock ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- VRAM model and bus monitor ----------------
    logic [31:0] vram [0:4095];
    logic [31:0] rd_pipe;
    logic        preload;
    logic        log_en;
    int          wr_count;
    int          rd_count;
    int          overlap_errs;
    int          be_errs;
    int          busy_cycles;
    logic [15:0] last_wraddr;
    logic [47:0] wr_log[$];
    logic [47:0] exp_q[$];

    function automatic logic [31:0] pat(input int i);
        logic [11:0] v;
        v = 12'(i);
        return {8'h00, v, 12'h02A};
    endfunction

    initial begin
        wr_count     = 0;
        rd_count     = 0;
        overlap_errs = 0;
        be_errs      = 0;
        busy_cycles  = 0;
        last_wraddr  = '0;
        rd_pipe      = '0;
    end

    always @(posedge CLK) begin
        if (preload) begin
            for (int i = 0; i < 4000; i++) vram[i] <= pat(i);
        end
        if (WREN) begin
            vram[WRADDR[13:2]] <= WRDATA;
            wr_count    <= wr_count + 1;
            last_wraddr <= WRADDR;
            if (log_en) wr_log.push_back({WRADDR, WRDATA});
            if (BYTEEN != 4'b0111) be_errs <= be_errs + 1;
        end
        if (RDEN) begin
            rd_pipe  <= vram[RDADDR[13:2]];
            rd_count <= rd_count + 1;
        end
        if (WREN && RDEN) overlap_errs <= overlap_errs + 1;
        if (BUSY) busy_cycles <= busy_cycles + 1;
    end

    // Upper byte carries junk that the console must ignore.
    assign RDDATA = {8'hA5, rd_pipe[23:0]};

    // ---------------- checking ----------------
    int checks;
    int failures;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] code, input logic [11:0] color);
        int n;
        n = 0;
        while (!CH_READY && n < 20000) begin
            @(posedge CLK);
            #1;
            n++;
        end
        if (!CH_READY) check("ready_timeout", {31'd0, CH_READY}, 32'd1);
        CH_CODE  = code;
        CH_COLOR = color;
        CH_VALID = 1'b1;
        @(posedge CLK);
        #1;
        CH_VALID = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (BUSY && n < budget) begin
            @(posedge CLK);
            #1;
            n++;
        end
        if (BUSY) check("idle_timeout", {31'd0, BUSY}, 32'd0);
    endtask

    task automatic apply_reset();
        RST = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        #1;
    endtask

    task automatic goto_last_row();
        for (int k = 0; k < 49; k++) send_byte(8'h0A, 12'h000);
    endtask

    // ---------------- stimulus ----------------
    int          wr0;
    int          rd0;
    int          busy0;
    int          errs;
    logic [47:0] a;
    logic [47:0] e;
    logic [7:0]  c;
    logic [11:0] clr;

    initial begin
        checks   = 0;
        failures = 0;
        RST      = 1'b1;
        CH_VALID = 1'b0;
        CH_CODE  = 8'h00;
        CH_COLOR = 12'h000;
        preload  = 1'b0;
        log_en   = 1'b0;

        // Reset state, sampled while RST is still high.
        repeat (3) @(posedge CLK);
        #1;
        check("rst_ready",  {31'd0, CH_READY}, 32'd0);
        check("rst_wren",   {31'd0, WREN}, 32'd0);
        check("rst_rden",   {31'd0, RDEN}, 32'd0);
        check("rst_wraddr", {16'd0, WRADDR}, 32'd0);
        check("rst_rdaddr", {16'd0, RDADDR}, 32'd0);
        check("rst_wrdata", WRDATA, 32'd0);
        check("rst_byteen", {28'd0, BYTEEN}, 32'd0);
        check("rst_col",    {25'd0, CUR_COL}, 32'd0);
        check("rst_row",    {26'd0, CUR_ROW}, 32'd0);
        check("rst_busy",   {31'd0, BUSY}, 32'd0);
        RST = 1'b0;
        #1;
        check("rst_ready_after", {31'd0, CH_READY}, 32'd1);

        // Single printable 'A', colour F00.
        wr0 = wr_count;
        send_byte(8'h41, 12'hF00);
        check("a_wren",   {31'd0, WREN}, 32'd1);
        check("a_wraddr", {16'd0, WRADDR}, 32'h0000);
        check("a_wrdata", WRDATA, 32'h000F0041);
        check("a_byteen", {28'd0, BYTEEN}, 32'h7);
        check("a_ready_busy", {31'd0, CH_READY}, 32'd0);
        @(posedge CLK);
        #1;
        check("a_wren_off", {31'd0, WREN}, 32'd0);
        check("a_col",      {25'd0, CUR_COL}, 32'd1);
        check("a_ready",    {31'd0, CH_READY}, 32'd1);
        check("a_wr_count", 32'(wr_count - wr0), 32'd1);

        // Full row of 80 printables wraps to row 1.
        apply_reset();
        wr_log.delete();
        exp_q.delete();
        log_en = 1'b1;
        for (int k = 0; k < 80; k++) begin
            c   = 8'(8'h20 + k);
            clr = 12'(k * 37);
            exp_q.push_back({16'(k * 4), 8'h00, 4'h0, clr, 1'b0, c[6:0]});
            send_byte(c, clr);
            wait_idle(10);
        end
        log_en = 1'b0;
        check("row_log_len", 32'(wr_log.size()), 32'd80);
        errs = 0;
        while (exp_q.size() > 0 && wr_log.size() > 0) begin
            e = exp_q.pop_front();
            a = wr_log.pop_front();
            if (a !== e) errs++;
        end
        check("row_write_errs", 32'(errs), 32'd0);
        check("row_last_addr",  {16'd0, last_wraddr}, 32'h013C);
        check("row_wrap_col",   {25'd0, CUR_COL}, 32'd0);
        check("row_wrap_row",   {26'd0, CUR_ROW}, 32'd1);

        // Control codes at column 0 and mid-row.
        apply_reset();
        wr0 = wr_count;
        send_byte(8'h0D, 12'h000);
        check("cr_col0", {25'd0, CUR_COL}, 32'd0);
        send_byte(8'h08, 12'h000);
        check("bs_col0", {25'd0, CUR_COL}, 32'd0);
        check("bs_row0", {26'd0, CUR_ROW}, 32'd0);
        check("ctl_no_write", 32'(wr_count - wr0), 32'd0);
        for (int k = 0; k < 5; k++) begin
            send_byte(8'h58, 12'h0F0);
            wait_idle(10);
        end
        check("col5", {25'd0, CUR_COL}, 32'd5);
        send_byte(8'h08, 12'h000);
        check("bs_col5", {25'd0, CUR_COL}, 32'd4);
        wr0 = wr_count;
        send_byte(8'h07, 12'h123);
        check("bel_col", {25'd0, CUR_COL}, 32'd4);
        check("bel_ready", {31'd0, CH_READY}, 32'd1);
        send_byte(8'hFF, 12'h123);
        check("ff_byte_col", {25'd0, CUR_COL}, 32'd4);
        check("ignored_no_write", 32'(wr_count - wr0), 32'd0);
        send_byte(8'h0D, 12'h000);
        check("cr_col4", {25'd0, CUR_COL}, 32'd0);

        // Scroll from row 49.
        apply_reset();
        goto_last_row();
        check("lf_row49", {26'd0, CUR_ROW}, 32'd49);
        preload = 1'b1;
        @(posedge CLK);
        #1;
        preload = 1'b0;
        wr0   = wr_count;
        rd0   = rd_count;
        busy0 = busy_cycles;
        send_byte(8'h0A, 12'h000);
        wait_idle(20000);
        #1;
        check("scr_writes", 32'(wr_count - wr0), 32'd4000);
        check("scr_reads",  32'(rd_count - rd0), 32'd3920);
        check("scr_busy",   32'(busy_cycles - busy0), 32'(3920 * 3 + 80));
        errs = 0;
        for (int i = 0; i < 3920; i++) if (vram[i] !== pat(i + 80)) errs++;
        check("scr_copy_errs", 32'(errs), 32'd0);
        errs = 0;
        for (int i = 3920; i < 4000; i++) if (vram[i] !== 32'h00000020) errs++;
        check("scr_blank_errs", 32'(errs), 32'd0);
        check("scr_col", {25'd0, CUR_COL}, 32'd0);
        check("scr_row", {26'd0, CUR_ROW}, 32'd49);
        check("scr_overlap", 32'(overlap_errs), 32'd0);

        // Form feed clears the whole screen.
        wr0 = wr_count;
        send_byte(8'h0C, 12'hFFF);
        wait_idle(5000);
        #1;
        check("ff_writes", 32'(wr_count - wr0), 32'd4000);
        check("ff_last_addr", {16'd0, last_wraddr}, 32'h3E7C);
        errs = 0;
        for (int i = 0; i < 4000; i++) if (vram[i] !== 32'h00000020) errs++;
        check("ff_blank_errs", 32'(errs), 32'd0);
        check("ff_col", {25'd0, CUR_COL}, 32'd0);
        check("ff_row", {26'd0, CUR_ROW}, 32'd0);

        // Reset in the middle of a scroll.
        goto_last_row();
        send_byte(8'h0A, 12'h000);
        repeat (100) @(posedge CLK);
        #1;
        check("mid_busy", {31'd0, BUSY}, 32'd1);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        check("mid_wren",  {31'd0, WREN}, 32'd0);
        check("mid_rden",  {31'd0, RDEN}, 32'd0);
        check("mid_state", {28'd0, DBG_STATE}, 32'd0);
        check("mid_col",   {25'd0, CUR_COL}, 32'd0);
        check("mid_row",   {26'd0, CUR_ROW}, 32'd0);
        RST = 1'b0;
        #1;
        check("mid_ready", {31'd0, CH_READY}, 32'd1);
        check("be_errs",   32'(be_errs), 32'd0);
        check("overlap_final", 32'(overlap_errs), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
